// File: rtl/bp_mem_block_ram.sv
// Block-granular test memory behind the memory transducer: one outstanding
// request, full-block response on a valid/yumi channel after latency_p cycles.
module bp_mem_block_ram #(
    parameter int block_width_p = 512,
    parameter int paddr_width_p = 40,
    parameter int els_p         = 64,
    parameter int latency_p     = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    output logic                       ready_o,
    input  logic                       v_i,
    input  logic                       w_i,
    input  logic [paddr_width_p-1:0]   addr_i,
    input  logic [block_width_p-1:0]   data_i,
    input  logic [block_width_p/8-1:0] write_mask_i,

    output logic [block_width_p-1:0]   data_o,
    output logic                       v_o,
    input  logic                       yumi_i
);

    // state     | meaning
    // st_idle   | ready for a request
    // st_wait   | request accepted, latency counter running
    // st_resp   | response valid, waiting for yumi

    localparam int block_offset_lp = $clog2(block_width_p/8);
    localparam int index_width_lp  = $clog2(els_p);
    localparam int bytes_lp        = block_width_p/8;
    localparam int cnt_width_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_wait = 2'd1;
    localparam logic [1:0] st_resp = 2'd2;

    localparam logic [cnt_width_lp-1:0] cnt_load_lp = cnt_width_lp'(latency_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

    logic [1:0]                state_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic [block_width_p-1:0]  resp_r;
    logic [block_width_p-1:0]  mem_r [els_p];
    logic [block_width_p-1:0]  merged;
    logic [index_width_lp-1:0] idx;
    logic                      accept;
    logic                      addr_unused;

    assign idx         = addr_i[block_offset_lp +: index_width_lp];
    assign addr_unused = ^addr_i;
    assign accept      = v_i & ready_o;

    assign ready_o = (state_r == st_idle);
    assign v_o     = (state_r == st_resp);
    assign data_o  = resp_r;

    // Post-write view of the indexed block; equals the stored block for reads.
    always_comb begin
        merged = mem_r[idx];
        if (w_i) begin
            for (int j = 0; j < bytes_lp; j++) begin
                if (write_mask_i[j]) begin
                    merged[8*j +: 8] = data_i[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && w_i) begin
            for (int j = 0; j < bytes_lp; j++) begin
                if (write_mask_i[j]) begin
                    mem_r[idx][8*j +: 8] <= data_i[8*j +: 8];
                end
            end
        end
    end

    // The counter hits zero on the edge that enters st_resp, so v_o rises
    // exactly latency_p cycles after the accept cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= st_idle;
            cnt_r   <= '0;
            resp_r  <= '0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (accept) begin
                        resp_r <= merged;
                        if (latency_p == 1) begin
                            state_r <= st_resp;
                        end else begin
                            state_r <= st_wait;
                            cnt_r   <= cnt_load_lp;
                        end
                    end
                end
                st_wait: begin
                    cnt_r <= cnt_r - cnt_one_lp;
                    if (cnt_r == cnt_one_lp) begin
                        state_r <= st_resp;
                    end
                end
                st_resp: begin
                    if (yumi_i) begin
                        state_r <= st_idle;
                    end
                end
                default: state_r <= st_idle;
            endcase
        end
    end

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: doc/bp_mem_block_ram.md
# bp_mem_block_ram

Block-granular test memory that sits directly downstream of the memory transducer in the ME testbench. It consumes the transducer's mem-side request bus (valid/write/addr/block data/byte mask) and returns a full cache block on a valid/yumi response channel after a programmable latency. It has one outstanding request at a time: `ready_o` stays low from accept until the response is consumed, which matches the transducer's single-entry command register.

## Interface
- `block_width_p`, 512: block width in bits; a multiple of 8.
- `paddr_width_p`, 40: byte address width.
- `els_p`, 64: number of blocks stored; a power of 2, ≥2.
- `latency_p`, 4: cycles from accept to first `v_o`; ≥1.
- `block_offset_lp` (local) = clog2(block_width_p/8); `index_width_lp` (local) = clog2(els_p).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; one clock, reset is asynchronous and active-low.
- `ready_o`  out  1  can accept a request this cycle.
- `v_i`  in  1  request valid; accepted when `v_i & ready_o`.
- `w_i`  in  1  request is a write; else read.
- `addr_i`  in  paddr_width_p  byte address; bits below block_offset_lp ignored.
- `data_i`  in  block_width_p  write data, already lane-aligned.
- `write_mask_i`  in  block_width_p/8  byte enables; bit j covers data bits [8j+7:8j].
- `data_o`  out  block_width_p  response block.
- `v_o`  out  1  response valid.
- `yumi_i`  in  1  response consumed; legal only while `v_o`=1.

## Operation
- Index = `addr_i[block_offset_lp +: index_width_lp]`. Higher address bits are ignored, so addresses alias modulo els_p blocks.
- FSM states:
  - IDLE: `ready_o`=1. On accept, go to WAIT and load the counter with latency_p-1.
  - WAIT: `ready_o`=0. Decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: `v_o`=1. On `yumi_i`, go to IDLE.
- If latency_p=1, accept goes straight from IDLE to RESP.
- Write on accept:
  - For every j with `write_mask_i[j]`=1, byte j of the indexed block takes `data_i` byte j at the accept edge. Unmasked bytes are unchanged.
  - An all-zero mask writes nothing but still produces a response.
- Read on accept: the indexed block is captured into a response register at the accept edge.
- Write response: `data_o` = the block contents after the write has been applied.
- `data_o` comes only from the response register. It is stable from the cycle `v_o` rises until yumi, and it holds its last value after yumi.
- Ignored inputs:
  - `v_i` while `ready_o`=0 is ignored; it has no side effects.
  - `yumi_i` while `v_o`=0 is ignored. Simulation asserts an error on it.
- Storage array is not reset. Contents are undefined until written.

## Timing
- Reset values: FSM=IDLE, `ready_o`=1, `v_o`=0, `data_o`=0, counter=0.
- Accept at cycle t:
  - `ready_o`=0 from t+1.
  - `v_o`=1 first in cycle t+latency_p.
  - `v_o` holds until the yumi cycle u inclusive.
- After yumi in cycle u: `v_o`=0 and `ready_o`=1 in u+1. No accept is possible in cycle u itself.
- Minimum request-to-request spacing is latency_p+1 cycles.
- Backpressure: `v_o` stays high indefinitely without `yumi_i`, with `data_o` unchanged.
- Reset asserted mid-operation, in WAIT or RESP: outputs return to their reset values immediately (asynchronously) and the pending response is discarded. A write already applied at its accept edge remains in storage.
- Read-after-write to the same index in back-to-back transactions returns the written data. There is no stale-read window.

## Test plan
- Write, full mask, addr 0x40 (index 1), data 0xA5 repeated; then read 0x40 → read `data_o` = 0xA5 repeated; each `v_o` arrives exactly latency_p cycles after accept.
- Partial mask: write 0x00 repeated, then write 0xFF…FF with mask 0x000F to addr 0x80 → response = all bytes 0 except bytes 0–3 = 0xFF; a subsequent read matches.
- Aliasing, els_p=64: write 0x11 repeated to addr 0x0, then read addr 64×64=0x1000 → returns 0x11 repeated.
- Backpressure: hold `yumi_i`=0 for 10 cycles in RESP → `v_o`=1 and `data_o` constant throughout; `ready_o`=0; `v_i` pulses during the hold have no effect on later reads.
- Reset mid-WAIT: accept a read, drop `reset_n_i` at t+2 → `v_o`=0 and `ready_o`=1 immediately; after release, a new read is accepted and answered after latency_p cycles.
- latency_p=1 build: accept at t → `v_o` at t+1; yumi at t+1 → `ready_o`=1 at t+2; 100 random masked writes and reads checked against a reference model.
